// File: rtl/vending_change_ctrl.sv
// Vending credit controller: accepts coins, strobes a vend at COST,
// then pays the remainder (or a cancelled credit) out one coin per handshake.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   coin_valid  in   coin present this cycle
//   coin_type   in   0=nickel 1=dime 2=quarter 3=invalid
//   cancel      in   refund request
//   coin_reject out  coin this cycle not credited (combinational)
//   dispense    out  one-cycle vend strobe
//   chg_valid   out  change coin request to hopper
//   chg_type    out  change coin: 0=nickel 1=dime 2=quarter
//   chg_ready   in   hopper accepts chg_type this cycle
//   busy        out  high in any state other than COLLECT
//   total       out  current credit in cents (registered)
module vending_change_ctrl #(
    parameter int unsigned COST = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       cancel,
    output logic       coin_reject,
    output logic       dispense,
    output logic       chg_valid,
    output logic [1:0] chg_type,
    input  logic       chg_ready,
    output logic       busy,
    output logic [7:0] total
);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_COLLECT = 2'd1,
        S_DISP    = 2'd2,
        S_CHANGE  = 2'd3
    } state_e;

    localparam logic [7:0] COST_W = 8'(COST);

    state_e     state_q, state_d;
    logic [7:0] total_q, total_d;

    logic [7:0] coin_val;
    logic [8:0] coin_sum;
    logic [7:0] chg_val;
    logic       coin_ok;

    always_comb begin
        coin_val = 8'd0;
        unique case (coin_type)
            2'd0:    coin_val = 8'd5;
            2'd1:    coin_val = 8'd10;
            2'd2:    coin_val = 8'd25;
            default: coin_val = 8'd0;
        endcase
    end

    // 9-bit sum so the COST comparison can never be fooled by a wrap.
    assign coin_sum = {1'b0, total_q} + {1'b0, coin_val};
    assign coin_ok  = coin_valid && (coin_type != 2'd3);

    // Largest coin that still fits in the remaining credit.
    always_comb begin
        chg_type = 2'd0;
        chg_val  = 8'd5;
        if (state_q == S_CHANGE) begin
            if (total_q >= 8'd25) begin
                chg_type = 2'd2;
                chg_val  = 8'd25;
            end else if (total_q >= 8'd10) begin
                chg_type = 2'd1;
                chg_val  = 8'd10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            total_q <= 8'd0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        unique case (state_q)
            S_INIT: begin
                total_d = 8'd0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                // Cancel with credit wins over any same-cycle coin.
                if (cancel && (total_q != 8'd0)) begin
                    state_d = S_CHANGE;
                end else if (coin_ok) begin
                    total_d = coin_sum[7:0];
                    if (coin_sum >= {1'b0, COST_W})
                        state_d = S_DISP;
                end
            end
            S_DISP: begin
                total_d = total_q - COST_W;
                state_d = (total_q == COST_W) ? S_INIT : S_CHANGE;
            end
            S_CHANGE: begin
                if (chg_ready) begin
                    total_d = total_q - chg_val;
                    state_d = (total_q == chg_val) ? S_INIT : S_CHANGE;
                end
            end
            default: begin
                state_d = S_INIT;
                total_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != S_COLLECT);
        dispense  = (state_q == S_DISP);
        chg_valid = (state_q == S_CHANGE);
        total     = total_q;
    end

    assign coin_reject = coin_valid &&
        (rst || (state_q != S_COLLECT) || (coin_type == 2'd3) ||
         (cancel && (total_q != 8'd0)));

endmodule

// File: tb/tb_vending_change_ctrl.sv
// Self-checking bench for vending_change_ctrl (COST=125): directed
// scenarios then random traffic, compared against a credit-level model.
module tb_vending_change_ctrl;

    localparam int COST = 125;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic       cancel = 1'b0;
    logic       coin_reject;
    logic       dispense;
    logic       chg_valid;
    logic [1:0] chg_type;
    logic       chg_ready = 1'b0;
    logic       busy;
    logic [7:0] total;

    vending_change_ctrl #(.COST(COST)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .cancel     (cancel),
        .coin_reject(coin_reject),
        .dispense   (dispense),
        .chg_valid  (chg_valid),
        .chg_type   (chg_type),
        .chg_ready  (chg_ready),
        .busy       (busy),
        .total      (total)
    );

    always #5 clk = ~clk;

    // Reference model: what the machine is doing, in the spec's terms.
    typedef enum int {P_INIT, P_COLLECT, P_VEND, P_PAY} phase_e;
    phase_e m_ph = P_INIT;
    int     m_credit = 0;
    bit     m_known = 1'b0;
    int     n_err = 0;
    int     n_chk = 0;
    int     n_disp = 0;
    int     n_pay = 0;

    function automatic int coin_cents(input int t);
        return (t == 0) ? 5 : (t == 1) ? 10 : (t == 2) ? 25 : 0;
    endfunction

    function automatic int change_kind(input int c);
        return (c >= 25) ? 2 : (c >= 10) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit rej;
        rej = coin_valid && (rst || m_ph != P_COLLECT || coin_type == 2'd3 ||
              (cancel && m_credit > 0));
        chk("busy", {8'd0, busy}, {8'd0, m_ph != P_COLLECT});
        chk("dispense", {8'd0, dispense}, {8'd0, m_ph == P_VEND});
        chk("chg_valid", {8'd0, chg_valid}, {8'd0, m_ph == P_PAY});
        chk("chg_type", {7'd0, chg_type},
            9'((m_ph == P_PAY) ? change_kind(m_credit) : 0));
        chk("total", {1'b0, total}, 9'(m_credit));
        chk("coin_reject", {8'd0, coin_reject}, {8'd0, rej});
    endtask

    task automatic update_model();
        if (rst) begin
            m_ph = P_INIT;
            m_credit = 0;
            m_known = 1'b1;
            return;
        end
        case (m_ph)
            P_INIT: begin
                m_credit = 0;
                m_ph = P_COLLECT;
            end
            P_COLLECT: begin
                if (cancel && m_credit > 0) begin
                    m_ph = P_PAY;
                end else if (coin_valid && coin_type != 2'd3) begin
                    m_credit += coin_cents(int'(coin_type));
                    if (m_credit >= COST) m_ph = P_VEND;
                end
            end
            P_VEND: begin
                n_disp++;
                m_credit -= COST;
                m_ph = (m_credit > 0) ? P_PAY : P_INIT;
            end
            P_PAY: begin
                if (chg_ready) begin
                    n_pay++;
                    m_credit -= coin_cents(change_kind(m_credit));
                    if (m_credit == 0) m_ph = P_INIT;
                end
            end
            default: m_ph = P_INIT;
        endcase
    endtask

    task automatic step(input bit v, input bit [1:0] t, input bit c,
                        input bit r, input bit rs);
        coin_valid = v;
        coin_type  = t;
        cancel     = c;
        chg_ready  = r;
        rst        = rs;
        #3;
        if (m_known) check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic quarters(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and settle into COLLECT
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 1: exact payment, no change
        quarters(5);
        chk("t1_total", {1'b0, total}, 9'd125);
        chk("t1_disp", {8'd0, dispense}, 9'd1);
        idle(3);
        chk("t1_collect_total", {1'b0, total}, 9'd0);

        // 2: 135 -> one dime back
        quarters(4);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        quarters(1);
        idle(1);
        chk("t2_chg_type", {7'd0, chg_type}, 9'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // 3: 120 + quarter, hopper stalls 3 cycles, then two dimes
        quarters(4);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        quarters(1);
        idle(4);
        chk("t3_hold_type", {7'd0, chg_type}, 9'd1);
        chk("t3_hold_total", {1'b0, total}, 9'd20);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("t3_total_10", {1'b0, total}, 9'd10);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("t3_total_0", {1'b0, total}, 9'd0);
        idle(2);

        // 4: cancel at 35 (coin during cancel rejected), then cancel at 0
        quarters(1);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        chk("t4_type_q", {7'd0, chg_type}, 9'd2);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("t4_cancel0_busy", {8'd0, busy}, 9'd0);
        chk("t4_cancel0_total", {1'b0, total}, 9'd5);
        step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // 5: invalid coin, coins during DISP/CHANGE, chg_ready outside CHANGE
        step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        quarters(5);
        step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        quarters(1);
        idle(2);

        // 6: reset mid-change with 20 owed
        quarters(4);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        quarters(1);
        idle(2);
        chk("t6_pre_total", {1'b0, total}, 9'd20);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t6_chg_valid", {8'd0, chg_valid}, 9'd0);
        chk("t6_busy", {8'd0, busy}, 9'd1);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 79) == 0));
        end
        chk("saw_dispense", {8'd0, n_disp > 0}, 9'd1);
        chk("saw_change", {8'd0, n_pay > 0}, 9'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
